sdm_window_accumulator: RTL
===========================

# sdm_window_accumulator

Decimating front-end for the iCESDM sigma-delta readout. The block consumes the 1-bit modulator bitstream and counts the ones over a fixed window of 2^WINDOW_LOG2 enabled samples. At the end of each window it hands the count downstream through a one-entry valid/ready output register. It sits between the modulator comparator and the mod-2^n counter/register stage, which loads its `o_data` as the preset value.

## Interface
- `WINDOW_LOG2`, default 7, log2 of the window length in enabled samples (window = 128).
- `i_clk`, input, 1, the only clock; every register updates on the rising edge.
- `i_rst_n`, input, 1, synchronous, active-low reset.
- `i_en`, input, 1, sample strobe; `i_bit` is counted only in cycles where this is high.
- `i_bit`, input, 1, sigma-delta bitstream sample.
- `i_clr`, input, 1, synchronous window restart.
- `i_ready`, input, 1, downstream accepts `o_data` this cycle.
- `o_data`, output, WINDOW_LOG2+1, ones count for the last completed window; range 0..2^WINDOW_LOG2.
- `o_valid`, output, 1, `o_data` holds an unaccepted result.
- `o_overrun`, output, 1, sticky flag: a completed window was dropped.

## Operation
- **Internal state.**
  - `smp_cnt` is WINDOW_LOG2 bits; it counts enabled samples and wraps modulo 2^WINDOW_LOG2.
  - `acc` is WINDOW_LOG2+1 bits; it holds the ones count of the current window.
- **Normal sample** (`i_en`=1, `i_clr`=0):
  - `acc` <= `acc` + `i_bit`.
  - `smp_cnt` <= `smp_cnt` + 1.
- **Window end:** an enabled sample with `smp_cnt` = 2^WINDOW_LOG2−1.
  - The result is `acc` + `i_bit`. It needs the full WINDOW_LOG2+1 bits; all ones gives exactly 2^WINDOW_LOG2.
  - `acc` <= 0 and `smp_cnt` wraps to 0 in the same edge. There is no gap, so the next sample belongs to the new window.
- **Output slot (two states).**
  - EMPTY: `o_valid`=0. FULL: `o_valid`=1.
  - Transfer occurs when `o_valid`=1 and `i_ready`=1.
  - Window end while EMPTY, or FULL with a transfer in the same cycle: load the result, `o_valid` <= 1.
  - Window end while FULL without a transfer: discard the result, `o_data` is unchanged, `o_overrun` <= 1.
  - Transfer with no window end: `o_valid` <= 0 and `o_data` holds its last value.
  - While `o_valid`=1 and `i_ready`=0, `o_data` must stay stable.
  - `i_ready` while EMPTY has no effect.
- **`o_overrun`** clears only on reset or `i_clr`.
- **`i_clr`:**
  - Clears `smp_cnt`, `acc`, `o_valid` and `o_overrun`; `o_data` <= 0.
  - The sample presented in the same cycle is discarded.
  - A pending result is dropped, with no handshake and no overrun.
- **Priority:** `i_rst_n`=0 > `i_clr` > window-end/transfer > normal sample.
- **`i_en`=0:** counters hold. The output handshake still operates (transfers complete).

## Timing
- **Reset:** every register updates only on an `i_clk` edge where `i_rst_n`=0; there is no asynchronous path. After that edge `o_data`=0, `o_valid`=0, `o_overrun`=0, `smp_cnt`=0, `acc`=0.
- **Latency:** `o_valid` rises at the same edge that samples the 2^WINDOW_LOG2-th enabled bit, i.e. it is visible the cycle after that bit is presented.
- **Throughput:** one result per 2^WINDOW_LOG2 enabled samples. With `i_ready` tied high, `o_valid` is a one-cycle pulse per window.
- **Ready timing:** `i_ready` is sampled combinationally with `o_valid` in the same cycle. It has no combinational path to any output.
- **Registers:** all outputs come straight from registers.

## Test plan
All scenarios use `WINDOW_LOG2`=3 (window 8, `o_data` 4 bits).

1. **Reset mid-operation.** Hold `i_rst_n`=0 for 2 cycles during a half-filled window with `o_valid`=1 → `o_data`=0, `o_valid`=0, `o_overrun`=0. The next window needs 8 fresh samples.
2. **Constant ones.** `i_bit`=1, `i_en`=1, `i_ready`=1 for 24 cycles → `o_data`=4'd8, with a one-cycle `o_valid` pulse after samples 8, 16 and 24.
3. **Alternating bits, then zeros.** Alternating 1,0 → `o_data`=4'd4 each window. All zeros → `o_data`=0 with `o_valid` still pulsing.
4. **Gated enable.** `i_en` high every other cycle, `i_bit`=1 (also 1 on disabled cycles) → a result every 16 clocks, `o_data`=4'd8.
5. **Backpressure and overrun.** `i_ready`=0, ones for 16 samples → first result 8 is held with `o_valid`=1; at sample 16 `o_overrun` rises and `o_data` stays 8. Then `i_ready`=1 for 1 cycle → `o_valid` falls. Also check a window end coinciding with the transfer: the new value loads and `o_valid` stays 1.
6. **Clear mid-window.** 5 ones, then `i_clr` with `i_bit`=1, then 8 samples of 1,1,0,0,1,1,0,0 → the first post-clear result is `o_data`=4'd4, and `o_overrun`=0.

Source files
------------

// File: rtl/sdm_window_accumulator.sv
// sdm_window_accumulator
// Counts ones in the 1-bit sigma-delta bitstream over a window of
// 2^WINDOW_LOG2 enabled samples. At the end of each window the count is
// handed downstream through a one-entry valid/ready output register.
//
// Ports
//   i_clk      : clock, all registers update on its rising edge
//   i_rst_n    : synchronous active-low reset
//   i_en       : sample strobe, i_bit counted only when high
//   i_bit      : modulator bitstream sample
//   i_clr      : synchronous window restart, drops any pending result
//   i_ready    : downstream accepts o_data this cycle
//   o_data     : ones count of the last completed window (0..2^WINDOW_LOG2)
//   o_valid    : o_data holds an unaccepted result
//   o_overrun  : sticky, a completed window was dropped
//
// Output slot
//   state      | meaning
//   SLOT_EMPTY | no result pending, o_valid = 0
//   SLOT_FULL  | result held in o_data until accepted, o_valid = 1
module sdm_window_accumulator #(
   parameter int WINDOW_LOG2 = 7
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_en,
   input  logic                   i_bit,
   input  logic                   i_clr,
   input  logic                   i_ready,
   output logic [WINDOW_LOG2:0]   o_data,
   output logic                   o_valid,
   output logic                   o_overrun
);

   localparam int CW = WINDOW_LOG2;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   slot_e         slot_q, slot_d;
   logic [CW-1:0] smp_cnt_q, smp_cnt_d;
   logic [CW:0]   acc_q, acc_d;
   logic [CW:0]   data_q, data_d;
   logic          overrun_q, overrun_d;

   logic          win_end;
   logic          xfer;
   logic [CW:0]   result;

   always_comb begin
      win_end   = i_en && (smp_cnt_q == {CW{1'b1}});
      xfer      = (slot_q == SLOT_FULL) && i_ready;
      // One extra bit so an all-ones window reads exactly 2^WINDOW_LOG2.
      result    = acc_q + (CW+1)'(i_bit);

      slot_d    = slot_q;
      smp_cnt_d = smp_cnt_q;
      acc_d     = acc_q;
      data_d    = data_q;
      overrun_d = overrun_q;

      if (i_clr) begin
         slot_d    = SLOT_EMPTY;
         smp_cnt_d = '0;
         acc_d     = '0;
         data_d    = '0;
         overrun_d = 1'b0;
      end else begin
         if (i_en) begin
            // Counter wraps to 0 at window end, so the next sample opens
            // the new window with no gap.
            smp_cnt_d = smp_cnt_q + CW'(1);
            acc_d     = win_end ? '0 : result;
         end
         if (win_end) begin
            // A transfer in the same cycle frees the slot for the new result.
            if ((slot_q == SLOT_EMPTY) || xfer) begin
               data_d = result;
               slot_d = SLOT_FULL;
            end else begin
               overrun_d = 1'b1;
            end
         end else if (xfer) begin
            slot_d = SLOT_EMPTY;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         slot_q    <= SLOT_EMPTY;
         smp_cnt_q <= '0;
         acc_q     <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         smp_cnt_q <= smp_cnt_d;
         acc_q     <= acc_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_data    = data_q;
   assign o_valid   = (slot_q == SLOT_FULL);
   assign o_overrun = overrun_q;

endmodule
